// File: rtl/pipelined_adder_pkg.sv
// Shared types and helpers for pipelined_ripple_adder.
// PIPELINED_RIPPLE_ADDER_OVF_EN adds the registered overflow bit to each stage record.
package pipelined_adder_pkg;

  // Upper bound on DATA_WIDTH so the stage record can be a fixed packed type.
  localparam int MAX_DW = 64;

  typedef struct packed {
    logic [MAX_DW-1:0] opa;
    logic [MAX_DW-1:0] opb;
    logic [MAX_DW-1:0] sum;
    logic              carry;
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    logic              ovf;
`endif
    logic              vld;
  } stage_t;

  function automatic int chunk_width(input int data_width, input int stages);
    return (stages > 0) ? data_width / stages : 1;
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CW-bit ripple-carry adder built from full-adder cells.
// PIPELINED_RIPPLE_ADDER_OVF_EN exposes the carry into the chunk MSB.
module adder_chunk #(
  parameter int CW = 2
) (
  input  logic [CW-1:0] a_i,
  input  logic [CW-1:0] b_i,
  input  logic          c_i,
  output logic [CW-1:0] s_o,
  output logic          c_o
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
  ,
  output logic          c_msb_o
`endif
);

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic z);
    return {(x & y) | (z & (x ^ y)), x ^ y ^ z};
  endfunction

  always_comb begin
    logic       c;
    logic [1:0] fa;
    c   = c_i;
    fa  = '0;
    s_o = '0;
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    c_msb_o = 1'b0;
`endif
    for (int i = 0; i < CW; i++) begin
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
      if (i == CW - 1) c_msb_o = c;
`endif
      fa     = full_add(a_i[i], b_i[i], c);
      s_o[i] = fa[0];
      c      = fa[1];
    end
    c_o = c;
  end

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Valid/ready pipelined adder: stage k adds operand chunk k and hands its carry to stage k+1.
// Optional PIPELINED_RIPPLE_ADDER_OVF_EN adds a registered two's-complement overflow output.
module pipelined_ripple_adder
  import pipelined_adder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STAGES     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  ci,
  input  logic                  din_vld,
  output logic                  din_rd,
  output logic [DATA_WIDTH-1:0] s,
  output logic                  co,
  output logic                  dout_vld,
  input  logic                  dout_rd
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
  ,
  output logic                  ovf
`endif
);

  localparam int CW = chunk_width(DATA_WIDTH, STAGES);

  if (STAGES < 1 || (DATA_WIDTH % STAGES) != 0 || DATA_WIDTH > MAX_DW) begin : g_bad_cfg
    $error("pipelined_ripple_adder: need STAGES >= 1, DATA_WIDTH %% STAGES == 0, DATA_WIDTH <= %0d",
           MAX_DW);
  end

  stage_t            stage_q [STAGES];
  stage_t            stage_d [STAGES];
  logic [STAGES-1:0] adv_d;

  // A stage loads when it is empty or its contents move on; evaluated from the output back.
  always_comb begin
    adv_d = '0;
    adv_d[STAGES-1] = !stage_q[STAGES-1].vld || dout_rd;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv_d[k] = !stage_q[k].vld || adv_d[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t        up;
    stage_t        nxt;
    logic [CW-1:0] sum_chunk;
    logic          carry_chunk;
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
    logic          c_msb;
`endif

    if (k == 0) begin : g_in
      always_comb begin
        up       = '0;
        up.opa   = MAX_DW'(a);
        up.opb   = MAX_DW'(b);
        up.carry = ci;
        up.vld   = din_vld;
      end
    end else begin : g_link
      assign up = stage_q[k-1];
    end

    adder_chunk #(
      .CW(CW)
    ) u_chunk (
      .a_i     (up.opa[k*CW +: CW]),
      .b_i     (up.opb[k*CW +: CW]),
      .c_i     (up.carry),
      .s_o     (sum_chunk),
      .c_o     (carry_chunk)
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
      ,
      .c_msb_o (c_msb)
`endif
    );

    always_comb begin
      nxt                  = up;
      nxt.sum[k*CW +: CW]  = sum_chunk;
      nxt.carry            = carry_chunk;
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
      nxt.ovf              = c_msb ^ carry_chunk;
`endif
    end

    assign stage_d[k] = nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) stage_q[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv_d[k]) stage_q[k] <= stage_d[k];
      end
    end
  end

  assign din_rd   = adv_d[0];
  assign s        = stage_q[STAGES-1].sum[DATA_WIDTH-1:0];
  assign co       = stage_q[STAGES-1].carry;
  assign dout_vld = stage_q[STAGES-1].vld;
`ifdef PIPELINED_RIPPLE_ADDER_OVF_EN
  assign ovf      = stage_q[STAGES-1].ovf;
`endif

  // Operand copies and unused sum bits end at the last stage.
  logic unused_tail;
  assign unused_tail = ^stage_q[STAGES-1];

endmodule
